ic_stimulus_sequencer: RTL

Drive-side sequencer for the logic IC tester. It applies the four two-input stimulus vectors to all four gates of a socketed 74-series IC and waits a settle time after each one. It then samples the IC outputs and checks each gate against the golden truth table for the selected IC type. It sits between the operator IC-select and start controls and the socket pins, and reports pass/fail with per-gate and per-vector fault masks.

---
 rtl/ic_stimulus_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ic_stimulus_sequencer.sv
// ic_stimulus_sequencer: drive-side sequencer for the logic IC tester.
// The block applies the four {a,b} vectors to all four gates of a socketed
// 74-series IC and holds each vector for a settle time. It then samples the
// gate outputs and grades them against the truth table of the selected IC.
// It reports pass/fail plus per-gate and per-vector fault masks.
// Optional build macro IC_SYNC_EN adds a 2-flop synchronizer on gate_y.
// When it is set, the APPLY phase is lengthened by 2 cycles to cover the
// synchronizer latency.
module ic_stimulus_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] ic_sel,
    input  logic [3:0] gate_y,
    output logic [3:0] drive_a,
    output logic [3:0] drive_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic       err,
    output logic [3:0] fail_mask,
    output logic [3:0] fail_vec
);

`ifdef IC_SYNC_EN
    localparam int unsigned APPLY_LEN = SETTLE_CYCLES + 2;
`else
    localparam int unsigned APPLY_LEN = SETTLE_CYCLES;
`endif
    // Last value of the settle counter before leaving APPLY.
    localparam logic [8:0] APPLY_LAST = 9'(APPLY_LEN - 1);

    localparam logic [2:0] SEL_INVALID = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE,
        ERR
    } state_t;

    state_t     state, state_d;
    logic [8:0] cnt, cnt_d;
    logic [1:0] vec, vec_d;
    logic [1:0] vec_nx;
    logic [2:0] sel, sel_d;
    logic [3:0] drive_a_d, drive_b_d;
    logic       busy_d, done_d, pass_d, fail_d, err_d;
    logic [3:0] fail_mask_d, fail_vec_d;
    logic       exp_bit;
    logic [3:0] mism;
    logic [3:0] mask_new;
    logic [3:0] gy_cmp;

    // Golden output of one gate of the selected IC for inputs a, b.
    function automatic logic expected_bit(input logic [2:0] s, input logic a, input logic b);
        logic r;
        case (s)
            3'b000:  r = ~(a & b);  // 7400 NAND
            3'b001:  r = ~(a | b);  // 7402 NOR
            3'b010:  r = ~a;        // 7404 NOT, b unused
            3'b011:  r = a & b;     // 7408 AND
            3'b100:  r = a | b;     // 7432 OR
            3'b101:  r = a ^ b;     // 7486 XOR
            3'b110:  r = ~(a ^ b);  // 74266 XNOR
            default: r = 1'b0;      // invalid, never graded
        endcase
        return r;
    endfunction

`ifdef IC_SYNC_EN
    logic [3:0] gy_meta, gy_sync;

    // Two-flop synchronizer on the asynchronous socket outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: synchronizer flops are reset too, so that the first compare
        // after reset never sees X from an uninitialised stage.
        if (rst) begin
            gy_meta <= '0;
            gy_sync <= '0;
        end else begin
            gy_meta <= gate_y;
            gy_sync <= gy_meta;
        end
    end

    assign gy_cmp = gy_sync;
`else
    assign gy_cmp = gate_y;
`endif

    assign vec_nx   = vec + 2'd1;
    assign exp_bit  = expected_bit(sel, vec[1], vec[0]);
    assign mism     = gy_cmp ^ {4{exp_bit}};
    assign mask_new = fail_mask | mism;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d     = state;
        cnt_d       = cnt;
        vec_d       = vec;
        sel_d       = sel;
        drive_a_d   = drive_a;
        drive_b_d   = drive_b;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        fail_d      = fail;
        err_d       = err;
        fail_mask_d = fail_mask;
        fail_vec_d  = fail_vec;

        case (state)
            IDLE: begin
                drive_a_d = '0;
                drive_b_d = '0;
                busy_d    = 1'b0;
                if (start) begin
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    err_d       = 1'b0;
                    fail_mask_d = '0;
                    fail_vec_d  = '0;
                    if (ic_sel == SEL_INVALID) begin
                        // Invalid IC: report immediately, never drive the socket.
                        state_d = ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        fail_d  = 1'b1;
                    end else begin
                        // v0 = {a,b} = 00, so the drives stay low on entry.
                        state_d = APPLY;
                        sel_d   = ic_sel;
                        vec_d   = 2'd0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end

            APPLY: begin
                if (cnt == APPLY_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt + 9'd1;
                end
            end

            SAMPLE: begin
                fail_mask_d = mask_new;
                if (|mism) begin
                    fail_vec_d[vec] = 1'b1;
                end
                if (vec == 2'd3) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    pass_d    = (mask_new == 4'd0);
                    fail_d    = (mask_new != 4'd0);
                    drive_a_d = '0;
                    drive_b_d = '0;
                end else begin
                    state_d   = APPLY;
                    vec_d     = vec_nx;
                    cnt_d     = '0;
                    drive_a_d = {4{vec_nx[1]}};
                    drive_b_d = {4{vec_nx[0]}};
                end
            end

            DONE: state_d = IDLE;

            ERR: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from the values present before the edge.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vec       <= 2'd0;
            sel       <= 3'd0;
            drive_a   <= '0;
            drive_b   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err       <= 1'b0;
            fail_mask <= '0;
            fail_vec  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            vec       <= vec_d;
            sel       <= sel_d;
            drive_a   <= drive_a_d;
            drive_b   <= drive_b_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail      <= fail_d;
            err       <= err_d;
            fail_mask <= fail_mask_d;
            fail_vec  <= fail_vec_d;
        end
    end

endmodule
